// File: rtl/bimodal_branch_predictor_pkg.sv
// Shared core definitions used by the bimodal branch predictor:
// branch opcodes, the 2-bit counter encoding and the tracking-slot control fields.
package bimodal_branch_predictor_pkg;

    // Opcodes (instruction bits [4:0]) that the predictor cares about.
    localparam logic [4:0] OP_BT  = 5'd23;
    localparam logic [4:0] OP_BF  = 5'd24;
    localparam logic [4:0] OP_JAL = 5'd25;

    // 2-bit saturating counter states; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Control part of a tracking slot. The address-sized fields depend on the
    // predictor parameters and are added by the predictor itself.
    typedef struct packed {
        logic valid;       // slot holds a BT/BF/JAL
        logic is_cond;     // BT/BF (trains the table), 0 for JAL
        logic pred_taken;  // prediction made at fetch
    } slot_ctl_t;

    // One step of a saturating counter: up counts toward ST, down toward SNT.
    function automatic ctr_e ctr_step(input ctr_e cur, input logic up);
        ctr_e nxt;
        case (cur)
            SNT:     nxt = up ? WNT : SNT;
            WNT:     nxt = up ? WT  : SNT;
            WT:      nxt = up ? ST  : WNT;
            ST:      nxt = up ? ST  : WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bimodal_branch_predictor_if.sv
// Fetch / execute side bus of the bimodal branch predictor.
// master = core pipeline, slave = predictor.
interface bimodal_branch_predictor_if #(
    parameter int PC_W  = 13,
    parameter int IMM_W = 17,
    parameter int CNT_W = 16
);
    // Pipeline control
    logic             stall;
    logic             halted;
    // Fetch side
    logic [PC_W-1:0]  fetch_pc;
    logic [4:0]       fetch_opcode;
    logic [IMM_W-1:0] fetch_imm;
    logic [PC_W-1:0]  next_pc;
    logic             predict_taken;
    // Execute side
    logic             resolve_valid;
    logic             resolve_taken;
    logic             mispredict;
    logic [PC_W-1:0]  recover_pc;
    // Performance counters
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output stall, halted, fetch_pc, fetch_opcode, fetch_imm,
               resolve_valid, resolve_taken,
        input  next_pc, predict_taken, mispredict, recover_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  stall, halted, fetch_pc, fetch_opcode, fetch_imm,
               resolve_valid, resolve_taken,
        output next_pc, predict_taken, mispredict, recover_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/bimodal_branch_predictor_sat_counter2.sv
// One 2-bit saturating up/down counter entry of the prediction table.
module sat_counter2
    import bimodal_branch_predictor_pkg::*;
#(
    parameter logic [1:0] INIT = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,   // apply one training step this clock
    input  logic       up_i,   // 1: branch was taken, 0: not taken
    output logic [1:0] cnt_o
);

    ctr_e cnt_q;
    ctr_e cnt_d;

    // Next counter value: step toward the observed outcome when enabled.
    always_comb begin
        if (en_i) begin
            cnt_d = ctr_step(cnt_q, up_i);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with asynchronous reset to the configured initial state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= ctr_e'(INIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit counters, two tracking
// slots (fetch->decode, decode->execute), mispredict detection with absolute
// recovery PC, and saturating performance counters.
module bimodal_branch_predictor
    import bimodal_branch_predictor_pkg::*;
#(
    parameter int         PC_W       = 13,
    parameter int         IMM_W      = 17,
    parameter int         DEPTH      = 64,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    bimodal_branch_predictor_if.slave    bp
);

    localparam int IDX_W = $clog2(DEPTH);
    // Intermediate width wide enough to sign-extend the immediate before
    // truncating it to the PC width.
    localparam int EXT_W = (PC_W > IMM_W) ? PC_W : IMM_W;

    // A branch in flight: control bits plus what is needed to train the
    // table and to rebuild the correct PC at execute.
    typedef struct packed {
        slot_ctl_t        ctl;
        logic [IDX_W-1:0] index;
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  imm;   // offset already sign-extended to PC_W
    } slot_t;

    // Sign-extend the raw immediate and truncate to a PC-width offset.
    function automatic logic [PC_W-1:0] imm_to_offset(input logic [IMM_W-1:0] imm);
        logic signed [IMM_W-1:0] imm_s;
        logic        [EXT_W-1:0] imm_ext;
        imm_s   = imm;
        imm_ext = EXT_W'(imm_s);
        return imm_ext[PC_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][1:0] tbl_s;

    logic [IDX_W-1:0]  fetch_idx_s;
    logic              fetch_is_cond_s;
    logic              fetch_is_jal_s;
    logic [1:0]        fetch_ctr_s;
    logic              fetch_taken_s;
    logic [PC_W-1:0]   fetch_off_s;
    logic [PC_W-1:0]   next_pc_s;
    slot_t             fetch_slot_s;

    slot_t             fd_q, fd_d;
    slot_t             ed_q, ed_d;

    logic              mispredict_s;
    logic              upd_en_s;
    logic [PC_W-1:0]   recover_pc_s;

    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    // ------------------------------------------------------------------
    // Counter table: one saturating counter per entry, trained at the
    // index captured when the branch was fetched.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        sat_counter2 #(
            .INIT (INIT_STATE)
        ) u_ctr (
            .clk   (clk),
            .rst   (reset),
            .en_i  (upd_en_s && (ed_q.index == IDX_W'(g))),
            .up_i  (bp.resolve_taken),
            .cnt_o (tbl_s[g])
        );
    end

    // ------------------------------------------------------------------
    // Fetch-side prediction
    // ------------------------------------------------------------------

    // Decode the fetched opcode, read the table and form the predicted next PC.
    always_comb begin
        fetch_idx_s     = bp.fetch_pc[IDX_W-1:0];
        fetch_is_cond_s = (bp.fetch_opcode == OP_BT) || (bp.fetch_opcode == OP_BF);
        fetch_is_jal_s  = (bp.fetch_opcode == OP_JAL);
        fetch_ctr_s     = tbl_s[fetch_idx_s];
        fetch_taken_s   = fetch_is_jal_s || (fetch_is_cond_s && fetch_ctr_s[1]);
        fetch_off_s     = imm_to_offset(bp.fetch_imm);
        if (fetch_taken_s) begin
            next_pc_s = bp.fetch_pc + fetch_off_s;
        end else begin
            next_pc_s = bp.fetch_pc + PC_W'(1);
        end
    end

    // Tracking-slot image of the instruction being fetched.
    always_comb begin
        fetch_slot_s                = '0;
        fetch_slot_s.ctl.valid      = fetch_is_cond_s || fetch_is_jal_s;
        fetch_slot_s.ctl.is_cond    = fetch_is_cond_s;
        fetch_slot_s.ctl.pred_taken = fetch_taken_s;
        fetch_slot_s.index          = fetch_idx_s;
        fetch_slot_s.pc             = bp.fetch_pc;
        fetch_slot_s.imm            = fetch_off_s;
    end

    // ------------------------------------------------------------------
    // Execute-side resolution
    // ------------------------------------------------------------------

    // Mispredict detection, table-update enable and the recovery PC.
    always_comb begin
        mispredict_s = ed_q.ctl.valid && ed_q.ctl.is_cond && bp.resolve_valid &&
                       (bp.resolve_taken != ed_q.ctl.pred_taken);
        upd_en_s     = !bp.halted && bp.resolve_valid &&
                       ed_q.ctl.valid && ed_q.ctl.is_cond;
        if (bp.resolve_taken) begin
            recover_pc_s = ed_q.pc + ed_q.imm;
        end else begin
            recover_pc_s = ed_q.pc + PC_W'(1);
        end
    end

    // Slot advance: halted freezes, a mispredict flushes both slots, a stall
    // holds FD and injects a bubble into ED, otherwise the pipe moves on.
    always_comb begin
        fd_d = fd_q;
        ed_d = ed_q;
        if (bp.halted) begin
            fd_d = fd_q;
            ed_d = ed_q;
        end else if (mispredict_s) begin
            fd_d = '0;
            ed_d = '0;
        end else if (bp.stall) begin
            fd_d = fd_q;
            ed_d = '0;
        end else begin
            fd_d = fetch_slot_s;
            ed_d = fd_q;
        end
    end

    // Tracking slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fd_q <= '0;
            ed_q <= '0;
        end else begin
            fd_q <= fd_d;
            ed_q <= ed_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (saturate at all-ones)
    // ------------------------------------------------------------------

    // Next values of the branch and mispredict counters.
    always_comb begin
        if (upd_en_s && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (!bp.halted && mispredict_s && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bp.next_pc          = next_pc_s;
    assign bp.predict_taken    = fetch_taken_s;
    assign bp.mispredict       = mispredict_s;
    assign bp.recover_pc       = recover_pc_s;
    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Self-checking bench for bimodal_branch_predictor: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_bimodal_branch_predictor;

    localparam int PC_W    = 13;
    localparam int IMM_W   = 17;
    localparam int DEPTH   = 64;
    localparam int CNT_W   = 5;      // small so saturation is reachable
    localparam int CNT_MAX = 31;
    localparam int PC_MOD  = 8192;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bimodal_branch_predictor_if #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

    bimodal_branch_predictor #(
        .PC_W       (PC_W),
        .IMM_W      (IMM_W),
        .DEPTH      (DEPTH),
        .INIT_STATE (2'b01),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Current stimulus (the bench's own copy of what it drives)
    bit in_st, in_hl, in_rv, in_rt;
    int in_pc, in_op, in_imm;

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit cond;
        bit pt;
        int idx;
        int pc;
        int imm;
    } mslot_t;

    int     m_tbl [DEPTH];
    mslot_t m_fd, m_ed;
    int     m_bc, m_mc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        if (v >= 65536) return v - 131072;
        return v;
    endfunction

    function automatic int wrap_pc(input int v);
        return ((v % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    function automatic bit m_is_cond(input int op);
        return (op == 23) || (op == 24);
    endfunction

    function automatic bit m_taken(input int pc, input int op);
        if (op == 25) return 1'b1;
        return m_is_cond(op) && (m_tbl[pc % DEPTH] >= 2);
    endfunction

    function automatic int m_next(input int pc, input int op, input int imm);
        if (m_taken(pc, op)) return wrap_pc(pc + sx(imm));
        return wrap_pc(pc + 1);
    endfunction

    function automatic bit m_mp();
        return m_ed.v && m_ed.cond && in_rv && (in_rt != m_ed.pt);
    endfunction

    function automatic int m_recover();
        if (in_rt) return wrap_pc(m_ed.pc + sx(m_ed.imm));
        return wrap_pc(m_ed.pc + 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
        m_fd.v = 1'b0;
        m_ed.v = 1'b0;
        m_bc   = 0;
        m_mc   = 0;
    endtask

    task automatic model_clock();
        mslot_t nf;
        bit     mp;
        bit     upd;
        mp      = m_mp();
        upd     = in_rv && m_ed.v && m_ed.cond;
        nf.v    = m_is_cond(in_op) || (in_op == 25);
        nf.cond = m_is_cond(in_op);
        nf.pt   = m_taken(in_pc, in_op);
        nf.idx  = in_pc % DEPTH;
        nf.pc   = in_pc;
        nf.imm  = in_imm;
        if (!in_hl) begin
            if (upd) begin
                if (in_rt) m_tbl[m_ed.idx] = (m_tbl[m_ed.idx] < 3) ? m_tbl[m_ed.idx] + 1 : 3;
                else       m_tbl[m_ed.idx] = (m_tbl[m_ed.idx] > 0) ? m_tbl[m_ed.idx] - 1 : 0;
                if (m_bc < CNT_MAX) m_bc++;
            end
            if (mp && m_mc < CNT_MAX) m_mc++;
            if (mp) begin
                m_fd.v = 1'b0;
                m_ed.v = 1'b0;
            end else if (in_st) begin
                m_ed.v = 1'b0;
            end else begin
                m_ed = m_fd;
                m_fd = nf;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs();
        check_val("next_pc",       32'(bus.next_pc),          32'(m_next(in_pc, in_op, in_imm)));
        check_val("predict_taken", 32'(bus.predict_taken),    32'(m_taken(in_pc, in_op)));
        check_val("mispredict",    32'(bus.mispredict),       32'(m_mp()));
        if (m_mp()) check_val("recover_pc", 32'(bus.recover_pc), 32'(m_recover()));
        check_val("branch_count",  32'(bus.branch_count),     32'(m_bc));
        check_val("mispred_count", 32'(bus.mispredict_count), 32'(m_mc));
    endtask

    task automatic drive(input bit st, input bit hl, input int pc, input int op,
                         input int imm, input bit rv, input bit rt);
        in_st = st; in_hl = hl; in_pc = pc; in_op = op; in_imm = imm; in_rv = rv; in_rt = rt;
        bus.stall         = st;
        bus.halted        = hl;
        bus.fetch_pc      = PC_W'(pc);
        bus.fetch_opcode  = 5'(op);
        bus.fetch_imm     = IMM_W'(imm);
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check_val("cnt_after_edge_b", 32'(bus.branch_count),     32'(m_bc));
        check_val("cnt_after_edge_m", 32'(bus.mispredict_count), 32'(m_mc));
    endtask

    task automatic nop(input bit rv, input bit rt);
        drive(1'b0, 1'b0, 0, 0, 0, rv, rt);
    endtask

    // Fetch one branch, let it reach execute and resolve it.
    task automatic run_branch(input int pc, input int op, input int imm, input bit rt);
        drive(1'b0, 1'b0, pc, op, imm, 1'b0, 1'b0); tick();
        nop(1'b0, 1'b0);                            tick();
        nop(1'b1, rt);                              tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_val("rst_branch_count",  32'(bus.branch_count),     32'd0);
        check_val("rst_mispred_count", 32'(bus.mispredict_count), 32'd0);
        check_val("rst_mispredict",    32'(bus.mispredict),       32'd0);
        reset = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 5, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset state
        check_val("reset_next_pc", 32'(bus.next_pc),          32'd6);
        check_val("reset_mispred", 32'(bus.mispredict),       32'd0);
        check_val("reset_bc",      32'(bus.branch_count),     32'd0);
        check_val("reset_mc",      32'(bus.mispredict_count), 32'd0);

        // BT at pc 5, imm 4: predicted not taken, resolves taken
        drive(1'b0, 1'b0, 5, 23, 4, 1'b0, 1'b0);
        check_val("bt5_pred", 32'(bus.predict_taken), 32'd0);
        check_val("bt5_next", 32'(bus.next_pc),       32'd6);
        tick();
        nop(1'b0, 1'b0); tick();
        nop(1'b1, 1'b1);
        check_val("bt5_mispred", 32'(bus.mispredict), 32'd1);
        check_val("bt5_recover", 32'(bus.recover_pc), 32'd9);
        tick();
        check_val("bt5_bc", 32'(bus.branch_count),     32'd1);
        check_val("bt5_mc", 32'(bus.mispredict_count), 32'd1);

        // Two more taken resolutions saturate the entry; then it predicts taken
        run_branch(5, 23, 4, 1'b1);
        run_branch(5, 23, 4, 1'b1);
        drive(1'b0, 1'b0, 5, 23, 4, 1'b0, 1'b0);
        check_val("bt5_sat_pred", 32'(bus.predict_taken), 32'd1);
        check_val("bt5_sat_next", 32'(bus.next_pc),       32'd9);
        tick();
        nop(1'b0, 1'b0); tick();
        nop(1'b1, 1'b1);
        check_val("bt5_sat_mispred", 32'(bus.mispredict), 32'd0);
        tick();
        check_val("bt5_sat_bc", 32'(bus.branch_count),     32'd4);
        check_val("bt5_sat_mc", 32'(bus.mispredict_count), 32'd1);

        // JAL: always taken, its resolve is ignored
        drive(1'b0, 1'b0, 2, 25, 17, 1'b0, 1'b0);
        check_val("jal_pred", 32'(bus.predict_taken), 32'd1);
        check_val("jal_next", 32'(bus.next_pc),       32'd19);
        tick();
        nop(1'b0, 1'b0); tick();
        nop(1'b1, 1'b0);
        check_val("jal_mispred", 32'(bus.mispredict), 32'd0);
        tick();
        check_val("jal_bc", 32'(bus.branch_count),     32'd4);
        check_val("jal_mc", 32'(bus.mispredict_count), 32'd1);

        // Negative offset: imm 0x1FFFE at pc 23 with counter trained to 11
        run_branch(23, 24, 'h1FFFE, 1'b1);
        run_branch(23, 24, 'h1FFFE, 1'b1);
        drive(1'b0, 1'b0, 23, 24, 'h1FFFE, 1'b0, 1'b0);
        check_val("neg_next", 32'(bus.next_pc), 32'd21);
        tick();
        nop(1'b0, 1'b0); tick();
        nop(1'b1, 1'b1); tick();

        // PC wrap on recovery: predicted-taken branch at 8191 resolves not taken
        run_branch(8191, 24, 5, 1'b1);
        run_branch(8191, 24, 5, 1'b1);
        drive(1'b0, 1'b0, 8191, 24, 5, 1'b0, 1'b0);
        check_val("wrap_pred", 32'(bus.predict_taken), 32'd1);
        tick();
        nop(1'b0, 1'b0); tick();
        nop(1'b1, 1'b0);
        check_val("wrap_mispred", 32'(bus.mispredict), 32'd1);
        check_val("wrap_recover", 32'(bus.recover_pc), 32'd0);
        tick();

        // Stall for 3 cycles with a branch in FD: only bubbles reach ED
        drive(1'b0, 1'b0, 10, 23, 3, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 40, 23, 1, 1'b1, 1'b1);
            check_val("stall_no_mispred", 32'(bus.mispredict), 32'd0);
            tick();
        end
        nop(1'b1, 1'b1);
        check_val("stall_release_bubble", 32'(bus.mispredict), 32'd0);
        tick();
        nop(1'b1, 1'b1);
        check_val("stall_branch_mispred", 32'(bus.mispredict), 32'd1);
        check_val("stall_branch_recover", 32'(bus.recover_pc), 32'd13);
        tick();

        // Halted with a resolving mispredict in ED: everything frozen
        drive(1'b0, 1'b0, 12, 23, 6, 1'b0, 1'b0); tick();
        nop(1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b1);
            check_val("halt_mispred_seen", 32'(bus.mispredict), 32'd1);
            tick();
        end
        check_val("halt_bc", 32'(bus.branch_count),     32'(m_bc));
        nop(1'b1, 1'b1);
        check_val("unhalt_mispred",  32'(bus.mispredict), 32'd1);
        check_val("unhalt_recover",  32'(bus.recover_pc), 32'd18);
        tick();
        drive(1'b0, 1'b0, 12, 23, 6, 1'b0, 1'b0);
        check_val("unhalt_trained", 32'(bus.predict_taken), 32'd1);
        tick();

        // Asynchronous reset mid-stream: table back to 01, counters to 0
        do_reset();
        drive(1'b0, 1'b0, 5, 23, 4, 1'b0, 1'b0);
        check_val("post_rst_pred", 32'(bus.predict_taken), 32'd0);
        check_val("post_rst_next", 32'(bus.next_pc),       32'd6);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r, pc, op;
            r  = $urandom_range(0, 9);
            if (r <= 3)      op = 23;
            else if (r <= 6) op = 24;
            else if (r == 7) op = 25;
            else             op = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) pc = $urandom_range(0, 15);
            else                           pc = $urandom_range(0, PC_MOD - 1);
            if ($urandom_range(0, 299) == 0) do_reset();
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, pc, op,
                  $urandom_range(0, 131071), $urandom_range(0, 99) < 70,
                  $urandom_range(0, 1) == 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bimodal_branch_predictor.md
# bimodal_branch_predictor

Parametrised branch predictor for the 5-stage core, replacing the fixed-size predictor with the following:
- a PC-indexed table of 2-bit saturating counters;
- internal tracking of every in-flight branch from fetch to execute;
- absolute recovery-PC generation on mispredict;
- saturating performance counters.

It sits beside the fetch stage and is updated from the execute stage.

## Interface
Parameters:
- PC_W, 13, program-counter width
- IMM_W, 17, branch immediate width (instruction bits [31:15])
- DEPTH, 64, counter-table entries; power of two, at least 2
- INIT_STATE, 2'b01, counter reset value (weakly not-taken)
- CNT_W, 16, performance-counter width

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  asynchronous, active-high
- stall  in  1  decode hazard stall
- halted  in  1  debug freeze
- fetch_pc  in  PC_W  PC of the instruction being fetched
- fetch_opcode  in  5  instruction bits [4:0]
- fetch_imm  in  IMM_W  instruction bits [31:15], two's complement
- next_pc  out  PC_W  predicted next fetch PC (combinational)
- predict_taken  out  1  the current fetch is predicted taken (combinational)
- resolve_valid  in  1  a BT/BF instruction is in execute this cycle
- resolve_taken  in  1  actual outcome of that branch
- mispredict  out  1  flush request (combinational)
- recover_pc  out  PC_W  correct next PC when mispredict is high
- branch_count  out  CNT_W  number of resolved conditional branches
- mispredict_count  out  CNT_W  number of mispredicts

## Operation
- Opcodes come from the core package: BT=23, BF=24, JAL=25. The BT/BF sense is already folded into resolve_taken.
- Index = fetch_pc[$clog2(DEPTH)-1:0]. The counter's MSB is the taken prediction.
- Offsets: imm is sign-extended from IMM_W, then truncated to PC_W. All PC additions wrap modulo 2^PC_W.
- Prediction (combinational):
  - JAL: taken, next_pc = fetch_pc + imm.
  - BT/BF with counter MSB=1: taken, next_pc = fetch_pc + imm.
  - Otherwise: not taken, next_pc = fetch_pc + 1.
- Tracking slots FD and ED each hold: valid, is_cond, pred_taken, index, pc, imm.
  - FD is loaded on a non-stalled fetch of BT, BF or JAL; any other opcode loads valid=0.
  - ED takes FD's contents on a non-stalled clock.
- mispredict = ED.valid & ED.is_cond & resolve_valid & (resolve_taken != ED.pred_taken).
- recover_pc = ED.pc + (resolve_taken ? imm : 1). It is meaningful only while mispredict is high.
- Table update on resolve_valid & ED.valid & ED.is_cond, at ED.index:
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- Counters:
  - branch_count increments on every table update.
  - mispredict_count increments on every mispredict.
  - Both saturate at all-ones and never wrap.
- Priority per clock, highest first:
  1. reset
  2. halted: all state frozen, including table and counters
  3. mispredict: FD and ED set invalid; the table update still occurs
  4. stall: FD holds, ED loads a bubble
  5. normal advance
- Bypass: a fetch read and an update to the same index in one cycle return the pre-update value; there is no bypass.
- resolve_valid while ED is invalid or is a JAL: ignored, with no update and no count.

## Timing
- Reset values:
  - all table entries = INIT_STATE
  - FD and ED valid = 0
  - both counters = 0
  - mispredict = 0
  - next_pc = fetch_pc + 1 (or the JAL target)
- Reset asserted mid-operation clears everything asynchronously. The first prediction after release uses INIT_STATE.
- Prediction latency: 0 cycles (combinational from fetch inputs and the table).
- Resolution: a branch fetched at cycle N, with no stall, is in ED at N+2. mispredict and recover_pc are valid during that cycle, combinationally from resolve_*.
- The table and counters reflect an update from the edge ending the resolve cycle. A fetch of the same index in the next cycle sees the new value.
- Each stall cycle delays ED by one cycle; a bubble in ED never asserts mispredict.

## Structure
- Extend the shared core package (cpu_pkg) with:
  - the opcode constants BT, BF, JAL;
  - a 2-bit counter enum: SNT=00, WNT=01, WT=10, ST=11;
  - a typedef for a tracking slot.
- One sub-module: sat_counter2, a 2-bit saturating up/down counter. It is instantiated DEPTH times, or used as a function over a packed array.
- Performance counters are inline.

## Test plan
- Reset, fetch BT at pc 5 with imm 4 → predict_taken=0, next_pc=6. Resolve taken at N+2 → mispredict=1, recover_pc=9, entry 5 becomes 10, branch_count=1, mispredict_count=1.
- Resolve the same BT taken twice more → counter saturates at 11; third fetch predicts taken, next_pc=9, mispredict=0.
- JAL at pc 2 with imm 17 → next_pc=19 with no table read dependency. Its resolve is ignored and counters are unchanged.
- Branch with imm 17'h1FFFE at pc 23, counter 11 → next_pc=21. With PC_W=13, a branch at pc 8191 not taken → recover_pc=0 (wrap).
- stall held 3 cycles with a branch in FD → ED shows bubbles and no mispredict; the branch reaches ED on the cycle after stall drops.
- halted asserted with a resolving mispredict → table, slots and counters are unchanged until halted drops. Reset asserted mid-stream → all counters return to 01 and perf counters to 0.
